demux_1ton: RTL and testbench

Registered 1-to-3 demultiplexer for the crossbar's valid/ready/payload fabric. It sits on each source-side path ahead of the per-destination N-to-1 arbiters. It accepts one beat stream carrying a destination select and steers each beat to exactly one of three destination ports, preserving source order. A two-entry input skid buffer and a one-entry output slice per destination give full throughput with no combinational path from any `rdy_dstK` to `rdy_src`. Beats with an out-of-range select are dropped and counted.

---
 rtl/demux_1ton_if.sv | 24 ++
 rtl/demux_1ton.sv | 125 ++++++++++++
 tb/tb_demux_1ton.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_1ton_if.sv
// demux_1ton_if: source-side and destination-side valid/ready/payload fabric
// of one crossbar source path. The slave modport is the demux's view.
interface demux_1ton_if #(
  parameter int PLD_W = 4
);
  logic             vld_src;
  logic [PLD_W-1:0] pld_src;
  logic [1:0]       sel_src;
  logic             rdy_src;

  logic             vld_dst0, vld_dst1, vld_dst2;
  logic [PLD_W-1:0] pld_dst0, pld_dst1, pld_dst2;
  logic             rdy_dst0, rdy_dst1, rdy_dst2;

  modport master (
    output vld_src, pld_src, sel_src, rdy_dst0, rdy_dst1, rdy_dst2,
    input  rdy_src, vld_dst0, vld_dst1, vld_dst2, pld_dst0, pld_dst1, pld_dst2
  );

  modport slave (
    input  vld_src, pld_src, sel_src, rdy_dst0, rdy_dst1, rdy_dst2,
    output rdy_src, vld_dst0, vld_dst1, vld_dst2, pld_dst0, pld_dst1, pld_dst2
  );
endinterface

// File: rtl/demux_1ton.sv
// demux_1ton: registered 1-to-3 demultiplexer. A two-entry skid buffer
// (head H, skid S) feeds one output slice per destination. rdy_src depends
// only on the S flop and rst, never on any destination ready.
module demux_1ton #(
  parameter int PLD_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  demux_1ton_if.slave      bus,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [1:0] SEL_DROP = 2'd3;

  logic             h_vld_q, h_vld_d;
  logic [PLD_W-1:0] h_pld_q, h_pld_d;
  logic [1:0]       h_sel_q, h_sel_d;
  logic             s_vld_q, s_vld_d;
  logic [PLD_W-1:0] s_pld_q, s_pld_d;
  logic [1:0]       s_sel_q, s_sel_d;
  logic [2:0]       vld_dst_q, vld_dst_d;
  logic [PLD_W-1:0] pld_dst_q [3];
  logic [PLD_W-1:0] pld_dst_d [3];
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [2:0] rdy_dst;
  logic [3:0] can_load;
  logic       rdy_src;
  logic       src_acc;
  logic       h_leave;

  // Handshake decode: slice readiness and whether the head beat departs.
  always_comb begin
    rdy_dst  = {bus.rdy_dst2, bus.rdy_dst1, bus.rdy_dst0};
    rdy_src  = !s_vld_q && !rst;
    src_acc  = bus.vld_src && rdy_src;
    // Select 3 is the drop path, which can always take the head beat.
    can_load = {1'b1, ~vld_dst_q | rdy_dst};
    h_leave  = h_vld_q && can_load[h_sel_q];
  end

  // Next state of the skid buffer, output slices and drop counter.
  always_comb begin
    // NOTE: every variable gets a hold-value default first so no path leaves it unassigned (no latch).
    h_vld_d    = h_vld_q;
    h_pld_d    = h_pld_q;
    h_sel_d    = h_sel_q;
    s_vld_d    = s_vld_q;
    s_pld_d    = s_pld_q;
    s_sel_d    = s_sel_q;
    vld_dst_d  = vld_dst_q;
    pld_dst_d  = pld_dst_q;
    drop_cnt_d = drop_cnt_q;

    if (h_leave) h_vld_d = 1'b0;

    if (!h_vld_q || h_leave) begin
      // Head is free next cycle: refill from S first, else from the source.
      if (s_vld_q) begin
        h_vld_d = 1'b1;
        h_pld_d = s_pld_q;
        h_sel_d = s_sel_q;
        s_vld_d = 1'b0;
      end else if (src_acc) begin
        h_vld_d = 1'b1;
        h_pld_d = bus.pld_src;
        h_sel_d = bus.sel_src;
      end
    end else if (src_acc) begin
      // Head is stalled: the accepted beat parks in S, which drops rdy_src.
      s_vld_d = 1'b1;
      s_pld_d = bus.pld_src;
      s_sel_d = bus.sel_src;
    end

    for (int k = 0; k < 3; k++) begin
      vld_dst_d[k] = vld_dst_q[k] && !rdy_dst[k];
      if (h_leave && h_sel_q == 2'(k)) begin
        vld_dst_d[k] = 1'b1;
        pld_dst_d[k] = h_pld_q;
      end
    end

    if (h_leave && h_sel_q == SEL_DROP && !(&drop_cnt_q))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  // Control state and output slices, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      h_vld_q    <= 1'b0;
      s_vld_q    <= 1'b0;
      vld_dst_q  <= '0;
      pld_dst_q  <= '{default: '0};
      drop_cnt_q <= '0;
    end else begin
      h_vld_q    <= h_vld_d;
      s_vld_q    <= s_vld_d;
      vld_dst_q  <= vld_dst_d;
      pld_dst_q  <= pld_dst_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Skid buffer data fields, qualified by their valid bits.
  always_ff @(posedge clk) begin
    // NOTE: data-only registers skip reset; their valid flags already mark them as don't-care.
    h_pld_q <= h_pld_d;
    h_sel_q <= h_sel_d;
    s_pld_q <= s_pld_d;
    s_sel_q <= s_sel_d;
  end

  assign bus.rdy_src  = rdy_src;
  assign bus.vld_dst0 = vld_dst_q[0];
  assign bus.vld_dst1 = vld_dst_q[1];
  assign bus.vld_dst2 = vld_dst_q[2];
  assign bus.pld_dst0 = pld_dst_q[0];
  assign bus.pld_dst1 = pld_dst_q[1];
  assign bus.pld_dst2 = pld_dst_q[2];
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_demux_1ton.sv
// tb_demux_1ton: directed timing tests plus a scoreboard that tracks every
// accepted legal beat per destination and every illegal beat.
module tb_demux_1ton;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld_src;
  logic [3:0] pld_src;
  logic [1:0] sel_src;
  logic [2:0] rdy_dst;
  logic [7:0] drop_cnt;

  logic [2:0] vd;
  logic [3:0] pd [3];

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;
  logic [3:0] exp_q [3][$];

  logic       stall_prev [3];
  logic [3:0] pld_prev   [3];
  logic       rst_prev = 1'b1;

  demux_1ton_if #(.PLD_W(4)) bus ();

  demux_1ton #(.PLD_W(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  assign bus.vld_src  = vld_src;
  assign bus.pld_src  = pld_src;
  assign bus.sel_src  = sel_src;
  assign bus.rdy_dst0 = rdy_dst[0];
  assign bus.rdy_dst1 = rdy_dst[1];
  assign bus.rdy_dst2 = rdy_dst[2];
  assign vd    = {bus.vld_dst2, bus.vld_dst1, bus.vld_dst0};
  assign pd[0] = bus.pld_dst0;
  assign pd[1] = bus.pld_dst1;
  assign pd[2] = bus.pld_dst2;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] p, input logic [1:0] s);
    vld_src = v;
    pld_src = p;
    sel_src = s;
  endtask

  // Scoreboard and output-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && vld_src && bus.rdy_src) begin
      if (sel_src == 2'd3) exp_drop++;
      else exp_q[sel_src].push_back(pld_src);
    end
    for (int k = 0; k < 3; k++) begin
      if (stall_prev[k] && !rst_prev) begin
        check($sformatf("stable_vld%0d", k), 32'(vd[k]), 32'd1);
        check($sformatf("stable_pld%0d", k), 32'(pd[k]), 32'(pld_prev[k]));
      end
      if (vd[k] && rdy_dst[k]) begin
        if (exp_q[k].size() == 0) check($sformatf("sb_extra%0d", k), 32'd1, 32'd0);
        else check($sformatf("sb_dst%0d", k), 32'(pd[k]), 32'(exp_q[k].pop_front()));
      end
      stall_prev[k] = vd[k] && !rdy_dst[k];
      pld_prev[k]   = pd[k];
    end
    rst_prev = rst;
    if (rst) begin
      for (int k = 0; k < 3; k++) exp_q[k].delete();
      exp_drop = 0;
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 2'd0);
    rdy_dst = 3'b111;
    for (int k = 0; k < 3; k++) begin
      stall_prev[k] = 1'b0;
      pld_prev[k]   = 4'h0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_src", 32'(bus.rdy_src), 32'd0);
    check("rst_vld", 32'(vd), 32'd0);
    check("rst_pld0", 32'(pd[0]), 32'd0);
    check("rst_pld2", 32'(pd[2]), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    step(); rst = 1'b0;
    @(negedge clk); check("rst_rel_rdy", 32'(bus.rdy_src), 32'd1);

    // Route: three beats to three destinations, two-cycle latency.
    step(); drive(1'b1, 4'h1, 2'd0);
    @(negedge clk); check("route_rdy_c0", 32'(bus.rdy_src), 32'd1);
    step(); drive(1'b1, 4'h2, 2'd1);
    @(negedge clk); check("route_rdy_c1", 32'(bus.rdy_src), 32'd1);
    step(); drive(1'b1, 4'h3, 2'd2);
    @(negedge clk);
    check("route_rdy_c2", 32'(bus.rdy_src), 32'd1);
    check("route_vld0_c2", 32'(vd), 32'b001);
    check("route_pld0_c2", 32'(pd[0]), 32'h1);
    step(); drive(1'b0, 4'h0, 2'd0);
    @(negedge clk);
    check("route_vld_c3", 32'(vd), 32'b010);
    check("route_pld1_c3", 32'(pd[1]), 32'h2);
    step();
    @(negedge clk);
    check("route_vld_c4", 32'(vd), 32'b100);
    check("route_pld2_c4", 32'(pd[2]), 32'h3);
    step();
    @(negedge clk); check("route_idle", 32'(vd), 32'd0);

    // Backpressure: dst0 stalled, three beats fit, fourth waits.
    step(); rdy_dst[0] = 1'b0; drive(1'b1, 4'hA, 2'd0);
    @(negedge clk); check("bp_rdy_c0", 32'(bus.rdy_src), 32'd1);
    step(); pld_src = 4'hB;
    @(negedge clk); check("bp_rdy_c1", 32'(bus.rdy_src), 32'd1);
    step(); pld_src = 4'hC;
    @(negedge clk);
    check("bp_rdy_c2", 32'(bus.rdy_src), 32'd1);
    check("bp_pld0_c2", 32'(pd[0]), 32'hA);
    step(); pld_src = 4'hD;
    @(negedge clk); check("bp_rdy_c3", 32'(bus.rdy_src), 32'd0);
    step();
    @(negedge clk);
    check("bp_rdy_c4", 32'(bus.rdy_src), 32'd0);
    check("bp_pld0_c4", 32'(pd[0]), 32'hA);
    step(); rdy_dst[0] = 1'b1;
    @(negedge clk);
    check("bp_rdy_c5", 32'(bus.rdy_src), 32'd0);
    check("bp_pld0_c5", 32'(pd[0]), 32'hA);
    step();
    @(negedge clk);
    check("bp_rdy_c6", 32'(bus.rdy_src), 32'd1);
    check("bp_pld0_c6", 32'(pd[0]), 32'hB);
    step(); vld_src = 1'b0;
    @(negedge clk); check("bp_pld0_c7", 32'(pd[0]), 32'hC);
    step();
    @(negedge clk);
    check("bp_vld0_c8", 32'(vd[0]), 32'd1);
    check("bp_pld0_c8", 32'(pd[0]), 32'hD);
    step();
    @(negedge clk); check("bp_vld0_c9", 32'(vd[0]), 32'd0);

    // Head-of-line: a blocked dst0 beat stalls a dst1 beat behind it.
    step(); rdy_dst[0] = 1'b0; drive(1'b1, 4'h5, 2'd0);
    step(); drive(1'b1, 4'h6, 2'd0);
    step(); drive(1'b1, 4'h7, 2'd1);
    step(); vld_src = 1'b0;
    @(negedge clk); check("hol_vld1_c3", 32'(vd[1]), 32'd0);
    for (int c = 4; c < 7; c++) begin
      step();
      @(negedge clk);
      check("hol_vld_stall", 32'(vd), 32'b001);
      check("hol_pld0_stall", 32'(pd[0]), 32'h5);
    end
    step(); rdy_dst[0] = 1'b1;
    @(negedge clk);
    check("hol_pld0_c7", 32'(pd[0]), 32'h5);
    check("hol_vld1_c7", 32'(vd[1]), 32'd0);
    step();
    @(negedge clk);
    check("hol_vld_c8", 32'(vd), 32'b001);
    check("hol_pld0_c8", 32'(pd[0]), 32'h6);
    step();
    @(negedge clk);
    check("hol_vld_c9", 32'(vd), 32'b010);
    check("hol_pld1_c9", 32'(pd[1]), 32'h7);

    // Drop: an illegal beat between two dst1 beats.
    step(); drive(1'b1, 4'h1, 2'd1);
    step(); drive(1'b1, 4'hF, 2'd3);
    step(); drive(1'b1, 4'h2, 2'd1);
    @(negedge clk);
    check("drop_vld1_c2", 32'(vd[1]), 32'd1);
    check("drop_pld1_c2", 32'(pd[1]), 32'h1);
    check("drop_cnt_c2", 32'(drop_cnt), 32'd0);
    step(); vld_src = 1'b0;
    @(negedge clk);
    check("drop_vld1_c3", 32'(vd[1]), 32'd0);
    check("drop_cnt_c3", 32'(drop_cnt), 32'd1);
    step();
    @(negedge clk);
    check("drop_vld1_c4", 32'(vd[1]), 32'd1);
    check("drop_pld1_c4", 32'(pd[1]), 32'h2);

    // Saturation: 300 more illegal beats pin the counter at all-ones.
    for (int i = 0; i < 300; i++) begin
      step(); drive(1'b1, 4'($urandom), 2'd3);
    end
    step(); vld_src = 1'b0;
    repeat (3) step();
    @(negedge clk); check("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset mid-flight: buffered beats vanish, counter clears.
    step(); rdy_dst[0] = 1'b0; drive(1'b1, 4'hA, 2'd0);
    step(); pld_src = 4'hB;
    step(); pld_src = 4'hC;
    step(); pld_src = 4'hD;
    step(); vld_src = 1'b0; rst = 1'b1;
    @(negedge clk); check("mid_rst_rdy", 32'(bus.rdy_src), 32'd0);
    step(); rst = 1'b0; rdy_dst[0] = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", 32'(bus.rdy_src), 32'd1);
    check("mid_drop", 32'(drop_cnt), 32'd0);
    for (int c = 0; c < 4; c++) begin
      check("mid_vld", 32'(vd), 32'd0);
      step();
      @(negedge clk);
    end

    // Random traffic; the scoreboard checks every destination transfer.
    for (int i = 0; i < 10000; i++) begin
      step();
      vld_src = 1'($urandom_range(0, 1));
      pld_src = 4'($urandom);
      sel_src = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      rdy_dst = 3'($urandom);
    end
    step(); vld_src = 1'b0; rdy_dst = 3'b111;
    repeat (10) step();
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("rand_left%0d", k), 32'(exp_q[k].size()), 32'd0);
    check("rand_drop", 32'(drop_cnt), 32'((exp_drop > 255) ? 255 : exp_drop));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
